bounce_step_ctrl: RTL and testbench

Step-rate controller placed directly upstream of the bouncing one-hot shift register. It generates that register's `ena` step pulses at a programmable clock-divided rate. It counts the register's `TC` bounce pulses fed back on `tc_in`, and runs either continuously or for a programmed number of bounces. Run control is by start/stop pulses, with a level-sensitive pause.

---
 rtl/bounce_step_ctrl.sv | 104 ++++++++++
 tb/tb_bounce_step_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bounce_step_ctrl.sv
// Step-rate controller for the bouncing one-hot shift register.
// Emits clock-divided ena step pulses, counts TC bounces on tc_in, and
// runs either continuously (bounces == 0) or until a bounce target is hit.
module bounce_step_ctrl #(
  parameter int DIV_WIDTH    = 16,
  parameter int BOUNCE_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rstna,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    pause,
  input  logic [DIV_WIDTH-1:0]    div,
  input  logic [BOUNCE_WIDTH-1:0] bounces,
  input  logic                    tc_in,
  output logic                    ena,
  output logic                    busy,
  output logic                    paused,
  output logic                    done,
  output logic [BOUNCE_WIDTH-1:0] bounce_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t                  state, state_d;
  logic [DIV_WIDTH-1:0]    cnt, cnt_d, div_q, div_d;
  logic [BOUNCE_WIDTH-1:0] target_q, target_d, bounce_d;
  logic                    ena_d, done_d;
  logic                    hit, complete;

  // Prescaler wraps when it reaches the latched period; a bounce completes
  // the run when it is the last one the target asks for.
  assign hit      = (cnt == div_q);
  assign complete = tc_in && (target_q != '0) &&
                    (bounce_cnt == target_q - BOUNCE_WIDTH'(1));

  assign busy   = (state != IDLE);
  assign paused = (state == PAUSED);

  // State register and all datapath registers; reset clears everything.
  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      state      <= IDLE;
      cnt        <= '0;
      div_q      <= '0;
      target_q   <= '0;
      bounce_cnt <= '0;
      ena        <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      div_q      <= div_d;
      target_q   <= target_d;
      bounce_cnt <= bounce_d;
      ena        <= ena_d;
      done       <= done_d;
    end
  end

  // Next-state and next-register values; priority stop > completion > pause.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    div_d    = div_q;
    target_d = target_q;
    bounce_d = bounce_cnt;
    ena_d    = 1'b0;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          div_d    = div;
          target_d = bounces;
          cnt_d    = '0;
          bounce_d = '0;
          state_d  = RUN;
        end
      end
      RUN, PAUSED: begin
        if (stop) begin
          state_d = IDLE;
        end else if (complete) begin
          bounce_d = target_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          if (tc_in) bounce_d = bounce_cnt + BOUNCE_WIDTH'(1);
          if (pause) begin
            state_d = PAUSED;
          end else begin
            // The cycle that leaves PAUSED steps too, so each paused
            // cycle costs exactly one clock of schedule.
            state_d = RUN;
            ena_d   = hit;
            cnt_d   = hit ? '0 : cnt + DIV_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bounce_step_ctrl.sv
// Directed bench for bounce_step_ctrl: a vector table for the short
// sequences plus hand-written runs for wrap, pause, and async reset.
module tb_bounce_step_ctrl;

  logic        clk = 1'b0;
  logic        rstna;
  logic        start, stop, pause, tc_in;
  logic [15:0] div;
  logic [7:0]  bounces;
  logic        ena, busy, paused, done;
  logic [7:0]  bounce_cnt;

  int nvec = 0;
  int nerr = 0;

  bounce_step_ctrl #(.DIV_WIDTH(16), .BOUNCE_WIDTH(8)) dut (
    .clk(clk), .rstna(rstna), .start(start), .stop(stop), .pause(pause),
    .div(div), .bounces(bounces), .tc_in(tc_in), .ena(ena), .busy(busy),
    .paused(paused), .done(done), .bounce_cnt(bounce_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, sp, pa, tc;
    logic [15:0] dv;
    logic [7:0]  bn;
    logic [11:0] exp;  // {ena, busy, paused, done, bounce_cnt}
    int          n;
  } vec_t;

  function automatic vec_t mk(logic st, logic sp, logic tc, logic [15:0] dv,
                              logic [7:0] bn, logic e, logic b, logic d,
                              logic [7:0] bc, int n);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = 1'b0; v.tc = tc; v.dv = dv; v.bn = bn;
    v.exp = {e, b, 1'b0, d, bc};
    v.n = n;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; stop = 1'b0; pause = 1'b0; tc_in = 1'b0;
  endtask

  function automatic logic [11:0] outs();
    return {ena, busy, paused, done, bounce_cnt};
  endfunction

  vec_t tbl[22];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic sawdone;
    int   e;
    //           st sp tc  dv  bn  ena busy done bc  n
    tbl[0]  = mk(1, 0, 0, 0,  2,  0, 1, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0,  0,  1, 1, 0, 0, 4);
    tbl[2]  = mk(0, 0, 1, 0,  0,  1, 1, 0, 1, 1);
    tbl[3]  = mk(0, 0, 0, 0,  0,  1, 1, 0, 1, 3);
    tbl[4]  = mk(0, 0, 1, 0,  0,  0, 0, 1, 2, 1);
    tbl[5]  = mk(0, 0, 0, 0,  0,  0, 0, 0, 2, 1);
    tbl[6]  = mk(1, 0, 0, 1,  3,  0, 1, 0, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0,  0,  0, 1, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0,  0,  1, 1, 0, 0, 1);
    tbl[9]  = mk(0, 0, 1, 0,  0,  0, 1, 0, 1, 1);
    tbl[10] = mk(0, 1, 0, 0,  0,  0, 0, 0, 1, 1);
    tbl[11] = mk(0, 0, 0, 0,  0,  0, 0, 0, 1, 1);
    tbl[12] = mk(1, 1, 0, 7,  0,  0, 0, 0, 1, 1);
    tbl[13] = mk(0, 0, 1, 0,  0,  0, 0, 0, 1, 1);
    tbl[14] = mk(1, 0, 0, 7,  0,  0, 1, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 0,  0,  0, 1, 0, 0, 2);
    tbl[16] = mk(1, 0, 0, 1,  5,  0, 1, 0, 0, 1);
    tbl[17] = mk(0, 0, 0, 0,  0,  0, 1, 0, 0, 4);
    tbl[18] = mk(0, 0, 0, 0,  0,  1, 1, 0, 0, 1);
    tbl[19] = mk(0, 0, 0, 0,  0,  0, 1, 0, 0, 7);
    tbl[20] = mk(0, 0, 0, 0,  0,  1, 1, 0, 0, 1);
    tbl[21] = mk(0, 1, 0, 0,  0,  0, 0, 0, 0, 1);

    // Reset and quiet idle
    rstna = 1'b0; idle_in(); div = '0; bounces = '0;
    #12 rstna = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("idle_after_reset[%0d]", k), 32'(outs()), 32'h0);
    end

    // Table: target-of-2 completion, stop, start+stop, period 8, start while busy
    for (int i = 0; i < 22; i++) begin
      for (int r = 0; r < tbl[i].n; r++) begin
        start = tbl[i].st; stop = tbl[i].sp; pause = tbl[i].pa; tc_in = tbl[i].tc;
        div = tbl[i].dv; bounces = tbl[i].bn;
        tick();
        chk($sformatf("tbl[%0d].%0d", i, r), 32'(outs()), 32'(tbl[i].exp));
      end
    end
    idle_in();

    // Continuous mode, div=3: ena every 4th edge, bounce counter wraps
    div = 16'd3; bounces = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("cont_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("cont_ena[%0d]", k), 32'(ena), 32'((k % 4) == 0));
    end
    sawdone = 1'b0;
    tc_in = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (done) sawdone = 1'b1;
    end
    tc_in = 1'b0;
    chk("cont_no_done", 32'(sawdone), 32'd0);
    chk("cont_wrap_cnt", 32'(bounce_cnt), 32'd44);
    chk("cont_still_busy", 32'(busy), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("cont_stopped", 32'({busy, done}), 32'd0);

    // Pause for 5 cycles starting 2 edges after an ena pulse, div=4
    div = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    e = 0;
    for (int k = 1; k <= 10 && e == 0; k++) begin
      tick();
      if (ena) e = k;
    end
    chk("pause_first_ena_at", 32'(e), 32'd5);
    tick();                                  // e+1
    pause = 1'b1;
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk($sformatf("pause_state[e+%0d]", k), 32'({ena, busy, paused}), 32'b011);
    end
    pause = 1'b0;
    for (int k = 7; k <= 10; k++) begin
      tick();
      chk($sformatf("pause_resume[e+%0d]", k), 32'({ena, busy, paused}),
          32'({k == 10, 1'b1, 1'b0}));
    end
    stop = 1'b1; tick(); stop = 1'b0;

    // Completion from PAUSED
    div = 16'd0; bounces = 8'd1; start = 1'b1;
    tick();
    start = 1'b0; pause = 1'b1;
    tick();
    chk("pc_paused", 32'({busy, paused}), 32'b11);
    tc_in = 1'b1;
    tick();
    tc_in = 1'b0; pause = 1'b0;
    chk("pc_done", 32'(outs()), 32'({1'b0, 1'b0, 1'b0, 1'b1, 8'd1}));
    tick();
    chk("pc_done_drop", 32'(outs()), 32'({4'b0000, 8'd1}));

    // Asynchronous reset mid-run
    div = 16'd2; bounces = 8'd0; start = 1'b1;
    tick();
    start = 1'b0; tc_in = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    tc_in = 1'b0;
    chk("rst_pre_cnt", 32'({busy, bounce_cnt}), 32'({1'b1, 8'd3}));
    #3 rstna = 1'b0;
    #1 chk("rst_async", 32'(outs()), 32'h0);
    #2 rstna = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("rst_after[%0d]", k), 32'(outs()), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
